adc_scale_cal: RTL and testbench

// - Converts raw ADC channel samples into real-value units: subtract a per-channel offset, multiply by a per-channel

---
 rtl/adc_scale_cal_if.sv | 31 +++
 rtl/adc_scale_cal.sv | 207 ++++++++++++++++++++
 tb/tb_adc_scale_cal.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scale_cal_if.sv
// Sample/config/result bundle between the ADC front end, the calibration
// block and its consumer. The slave side is the calibration block itself.
interface adc_scale_cal_if #(
    parameter int NCH    = 2,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 16,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) ();
    logic                  in_valid;
    logic [NCH*IN_W-1:0]   volt_in;
    logic                  cfg_we;
    logic [CH_W-1:0]       cfg_ch;
    logic [GAIN_W-1:0]     cfg_gain;
    logic [IN_W-1:0]       cfg_offset;
    logic                  busy;
    logic                  overrun;
    logic                  out_valid;
    logic [NCH*OUT_W-1:0]  out_data;
    logic [NCH-1:0]        sat_flag;

    modport master (
        output in_valid, volt_in, cfg_we, cfg_ch, cfg_gain, cfg_offset,
        input  busy, overrun, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, volt_in, cfg_we, cfg_ch, cfg_gain, cfg_offset,
        output busy, overrun, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/adc_scale_cal.sv
// Per-channel offset/gain calibration with a single time-shared signed
// multiplier, fixed-point shift, saturation and boxcar averaging.
//
// state | meaning
// IDLE  | waiting for a frame strobe
// CALC  | one channel per cycle through subtract/multiply/shift/saturate/accumulate
// ACC   | frame counted; window result published if complete; a new frame may be accepted
module adc_scale_cal #(
    parameter int NCH      = 2,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int GAIN_W   = 16,
    parameter int FRAC     = 10,
    parameter int AVG_LOG2 = 0,
    parameter logic [NCH*GAIN_W-1:0] DEF_GAINS = {16'sd500, 16'sd50}
) (
    input  logic            ad_clk,
    input  logic            rst_n,
    adc_scale_cal_if.slave  bus
);
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW    = IN_W + 1;
    localparam int PW    = IN_W + GAIN_W + 1;
    localparam int AW    = OUT_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [IW-1:0]    LAST = IW'(NCH - 1);
    localparam logic [CNT_W-1:0] WIN  = CNT_W'(1) << AVG_LOG2;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, ACC} state_t;

    state_t state, state_nxt;

    // runtime configuration
    logic signed [GAIN_W-1:0] gain_reg [NCH];
    logic signed [IN_W-1:0]   off_reg  [NCH];

    // frame snapshot
    logic signed [IN_W-1:0]   x_cap    [NCH];
    logic signed [GAIN_W-1:0] gain_cap [NCH];
    logic signed [IN_W-1:0]   off_cap  [NCH];

    logic [IW-1:0]            idx;
    logic signed [AW-1:0]     acc      [NCH];
    logic [NCH-1:0]           win_sat;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_inc;

    logic                     busy_q;
    logic                     overrun_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_q    [NCH];
    logic [NCH-1:0]           sat_q;

    logic accept, drop, calc_en, acc_en;

    // datapath for the channel currently selected by idx
    logic signed [DW-1:0]     diff;
    logic signed [PW-1:0]     diff_x, gain_x, prod, shifted;
    logic signed [OUT_W-1:0]  sat_val;
    logic signed [AW-1:0]     sat_ext;
    logic                     clip;

    assign diff    = DW'(x_cap[idx]) - DW'(off_cap[idx]);
    assign diff_x  = PW'(diff);
    assign gain_x  = PW'(gain_cap[idx]);
    assign prod    = diff_x * gain_x;
    assign shifted = prod >>> FRAC;
    assign sat_ext = AW'(sat_val);
    assign cnt_inc = cnt + CNT_W'(1);

    // clamp the shifted product to the output range and flag clipping
    always_comb begin
        clip    = 1'b0;
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            clip    = 1'b1;
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            clip    = 1'b1;
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    // state register
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state and per-cycle control strobes; ACC accepts a frame so the
    // block can sustain one frame every NCH+1 cycles
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        calc_en   = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                drop    = bus.in_valid;
                if (idx == LAST) state_nxt = ACC;
            end
            ACC: begin
                acc_en = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // config register file; a write in the capture cycle is seen by the next frame
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                gain_reg[i] <= DEF_GAINS[i*GAIN_W +: GAIN_W];
                off_reg[i]  <= '0;
            end
        end else if (bus.cfg_we && (int'(bus.cfg_ch) < NCH)) begin
            gain_reg[bus.cfg_ch] <= bus.cfg_gain;
            off_reg[bus.cfg_ch]  <= bus.cfg_offset;
        end
    end

    // frame capture, per-channel accumulation and window publish
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                x_cap[i]    <= '0;
                gain_cap[i] <= '0;
                off_cap[i]  <= '0;
                acc[i]      <= '0;
                out_q[i]    <= '0;
            end
            idx         <= '0;
            win_sat     <= '0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
        end else begin
            overrun_q   <= drop;
            out_valid_q <= 1'b0;

            if (accept) begin
                for (int i = 0; i < NCH; i++) begin
                    x_cap[i]    <= bus.volt_in[i*IN_W +: IN_W];
                    gain_cap[i] <= gain_reg[i];
                    off_cap[i]  <= off_reg[i];
                end
                idx <= '0;
            end

            if (accept)      busy_q <= 1'b1;
            else if (acc_en) busy_q <= 1'b0;

            if (calc_en) begin
                acc[idx]     <= acc[idx] + sat_ext;
                win_sat[idx] <= win_sat[idx] | clip;
                idx          <= idx + IW'(1);
            end

            if (acc_en) begin
                if (cnt_inc == WIN) begin
                    for (int i = 0; i < NCH; i++) begin
                        out_q[i] <= OUT_W'(acc[i] >>> AVG_LOG2);
                        acc[i]   <= '0;
                    end
                    sat_q       <= win_sat;
                    win_sat     <= '0;
                    cnt         <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // pack per-channel results onto the bus
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            bus.out_data[i*OUT_W +: OUT_W] = out_q[i];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_adc_scale_cal.sv
// Bench for adc_scale_cal: one instance with per-frame output and one with a
// four-frame window; expected results come from a behavioural model and are
// queued when frames are driven.
module tb_adc_scale_cal;
    logic ad_clk = 1'b0;
    logic rst_n  = 1'b0;

    always #5 ad_clk = ~ad_clk;

    adc_scale_cal_if #(.NCH(2), .IN_W(16), .OUT_W(16), .GAIN_W(16)) bus0 ();
    adc_scale_cal_if #(.NCH(2), .IN_W(16), .OUT_W(16), .GAIN_W(16)) bus1 ();

    adc_scale_cal #(.AVG_LOG2(0)) dut0 (.ad_clk(ad_clk), .rst_n(rst_n), .bus(bus0));
    adc_scale_cal #(.AVG_LOG2(2)) dut1 (.ad_clk(ad_clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sat;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int mgain [2] = '{50, 500};
    int moff  [2] = '{0, 0};
    int acc1      = 0;
    int frames1   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {sat, value} for one channel
    function automatic logic [16:0] model(input int x, input int g, input int off);
        longint d, p, s;
        logic   sat;
        d   = longint'(x) - longint'(off);
        p   = d * longint'(g);
        s   = p >>> 10;
        sat = 1'b0;
        if (s > 32767)       begin s = 32767;  sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        return {sat, s[15:0]};
    endfunction

    always @(posedge ad_clk) cyc <= cyc + 1;

    // scoreboard: pop and compare on every result pulse
    always @(negedge ad_clk) begin
        exp_t e;
        if (bus0.out_valid === 1'b1) begin
            if (q0.size() == 0) check_val("dut0_unexpected_valid", 1, 0);
            else begin
                e = q0.pop_front();
                check_val("dut0_data", bus0.out_data, e.data);
                check_val("dut0_sat", bus0.sat_flag, e.sat);
                check_val("dut0_latency_cyc", cyc, e.cyc);
            end
        end
        if (bus1.out_valid === 1'b1) begin
            if (q1.size() == 0) check_val("dut1_unexpected_valid", 1, 0);
            else begin
                e = q1.pop_front();
                check_val("dut1_data", bus1.out_data, e.data);
                check_val("dut1_sat", bus1.sat_flag, e.sat);
                check_val("dut1_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ad_clk);
            #1;
        end
    endtask

    task automatic push0(input int x0, input int x1);
        logic [16:0] r0, r1;
        r0 = model(x0, mgain[0], moff[0]);
        r1 = model(x1, mgain[1], moff[1]);
        q0.push_back('{data: {r1[15:0], r0[15:0]}, sat: {r1[16], r0[16]}, cyc: cyc + 1 + 3});
    endtask

    // frame held for one edge; optional config write in the same cycle
    task automatic frame0(input int x0, input int x1, input bit we, input int ch, input int g, input int off);
        logic [15:0] a, b;
        a = x0[15:0];
        b = x1[15:0];
        bus0.in_valid   = 1'b1;
        bus0.volt_in    = {b, a};
        bus0.cfg_we     = we;
        bus0.cfg_ch     = ch[0];
        bus0.cfg_gain   = g[15:0];
        bus0.cfg_offset = off[15:0];
        push0(x0, x1);
        if (we) begin
            mgain[ch] = g;
            moff[ch]  = off;
        end
        step(1);
        bus0.in_valid = 1'b0;
        bus0.cfg_we   = 1'b0;
    endtask

    task automatic cfg0(input int ch, input int g, input int off);
        bus0.cfg_we     = 1'b1;
        bus0.cfg_ch     = ch[0];
        bus0.cfg_gain   = g[15:0];
        bus0.cfg_offset = off[15:0];
        mgain[ch] = g;
        moff[ch]  = off;
        step(1);
        bus0.cfg_we = 1'b0;
    endtask

    task automatic frame1(input int x0);
        logic [16:0] r;
        logic [15:0] a;
        a = x0[15:0];
        bus1.in_valid = 1'b1;
        bus1.volt_in  = {16'd0, a};
        r = model(x0, 50, 0);
        acc1 += int'($signed(r[15:0]));
        frames1++;
        if (frames1 == 4) begin
            q1.push_back('{data: {16'd0, 16'(acc1 >>> 2)}, sat: 2'b00, cyc: cyc + 1 + 3});
            acc1    = 0;
            frames1 = 0;
        end
        step(1);
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            step(1);
            n++;
        end
        check_val(tag, q0.size() + q1.size(), 0);
    endtask

    initial begin
        bus0.in_valid = 0; bus0.volt_in = '0; bus0.cfg_we = 0; bus0.cfg_ch = '0;
        bus0.cfg_gain = '0; bus0.cfg_offset = '0;
        bus1.in_valid = 0; bus1.volt_in = '0; bus1.cfg_we = 0; bus1.cfg_ch = '0;
        bus1.cfg_gain = '0; bus1.cfg_offset = '0;

        #2;
        check_val("rst_out_data", bus0.out_data, 0);
        check_val("rst_sat", bus0.sat_flag, 0);
        check_val("rst_out_valid", bus0.out_valid, 0);
        check_val("rst_busy", bus0.busy, 0);
        check_val("rst_overrun", bus0.overrun, 0);
        #20 rst_n = 1'b1;
        step(1);

        // default gains
        frame0(1024, 1024, 0, 0, 0, 0);
        check_val("busy_after_accept", bus0.busy, 1);
        drain("drain_defaults");
        step(1);
        check_val("out_valid_single_pulse", bus0.out_valid, 0);
        check_val("out_data_held", bus0.out_data, {16'sd500, 16'sd50});

        // negative inputs, floor rounding
        frame0(-1, -2048, 0, 0, 0, 0);
        drain("drain_negative");

        // gain write at the capture edge: old gain for this frame, new for next
        frame0(1024, 32767, 1, 1, 32767, 0);
        drain("drain_same_edge_cfg");
        frame0(1024, 32767, 0, 0, 0, 0);
        drain("drain_saturate");

        // offsets, including the widest difference
        cfg0(0, 50, 100);
        frame0(1124, 0, 0, 0, 0, 0);
        drain("drain_offset");
        cfg0(0, 50, 32767);
        frame0(-32768, 0, 0, 0, 0, 0);
        drain("drain_no_wrap");
        cfg0(0, 50, 0);
        cfg0(1, 500, 0);

        // maximum rate: second frame lands as busy falls
        frame0(2048, 100, 0, 0, 0, 0);
        step(2);
        check_val("busy_before_fall", bus0.busy, 1);
        frame0(-2048, -100, 0, 0, 0, 0);
        check_val("no_overrun_at_max_rate", bus0.overrun, 0);
        drain("drain_max_rate");

        // back-to-back strobes: second dropped
        bus0.in_valid = 1'b1;
        bus0.volt_in  = {16'sd1024, 16'sd1024};
        push0(1024, 1024);
        step(1);
        bus0.volt_in  = {16'sd3000, 16'sd3000};
        step(1);
        bus0.in_valid = 1'b0;
        check_val("overrun_pulse", bus0.overrun, 1);
        step(1);
        check_val("overrun_clears", bus0.overrun, 0);
        drain("drain_overrun");
        step(4);

        // four-frame window on the averaging instance
        frame1(1024); step(2);
        frame1(2048); step(2);
        frame1(3072); step(2);
        check_val("avg_held_before_window", bus1.out_data, 0);
        frame1(4096);
        drain("drain_avg");
        step(5);
        check_val("avg_held_after", bus1.out_data, {16'd0, 16'sd125});
        check_val("avg_valid_low", bus1.out_valid, 0);

        // reset mid-CALC
        frame0(1024, 1024, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        void'(q0.pop_back());
        #1;
        check_val("midrst_out_data", bus0.out_data, 0);
        check_val("midrst_sat", bus0.sat_flag, 0);
        check_val("midrst_busy", bus0.busy, 0);
        check_val("midrst_valid", bus0.out_valid, 0);
        check_val("midrst_avg_data", bus1.out_data, 0);
        mgain = '{50, 500};
        moff  = '{0, 0};
        #10 rst_n = 1'b1;
        step(1);
        check_val("midrst_no_stray_valid", bus0.out_valid, 0);
        frame0(-1, -2048, 0, 0, 0, 0);
        drain("drain_after_reset");
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
